// File: rtl/fmrv32im_dbus_mailbox_pkg.sv
// Shared definitions for the fmrv32im dbus mailbox: register word offsets,
// STATUS bit positions and small helpers for status packing and byte-strobe merging.
package fmrv32im_dbus_mailbox_pkg;

  localparam logic [1:0] OFS_RESULT  = 2'd0;
  localparam logic [1:0] OFS_STATUS  = 2'd1;
  localparam logic [1:0] OFS_LED     = 2'd2;
  localparam logic [1:0] OFS_SCRATCH = 2'd3;

  localparam int STAT_OVF_BIT   = 15;
  localparam int STAT_FULL_BIT  = 7;
  localparam int STAT_EMPTY_BIT = 6;

  typedef struct packed {
    logic       hit;
    logic       rd;
    logic       wr;
    logic [1:0] ofs;
  } dbus_dec_t;

  function automatic logic [31:0] pack_status(input logic ovf, input logic full,
                                              input logic empty, input logic [4:0] count);
    logic [31:0] s;
    s                 = '0;
    s[STAT_OVF_BIT]   = ovf;
    s[STAT_FULL_BIT]  = full;
    s[STAT_EMPTY_BIT] = empty;
    s[4:0]            = count;
    return s;
  endfunction

  function automatic logic [31:0] apply_wstb(input logic [31:0] old, input logic [31:0] wdata,
                                             input logic [3:0] wstb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (wstb[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/fmrv32im_sync_fifo.sv
// Synchronous FIFO with a registered head word; a push into an empty FIFO
// shows up at the head one cycle later, and a push while full is taken only alongside a pop.
module fmrv32im_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   din,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [31:0]   head
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   head_q, head_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    // The head register looks ahead so the word being written can land at the head directly.
    if (count_d == '0)
      head_d = '0;
    else if (do_push && (wr_ptr_q == rd_ptr_d))
      head_d = din;
    else
      head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= din;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = head_q;

endmodule

// File: rtl/fmrv32im_dbus_mailbox.sv
// dbus responder for a 16-byte mailbox window: RESULT FIFO, STATUS, LED and SCRATCH.
// Define MAILBOX_BACKPRESSURE_EN to stall the core on a full FIFO instead of dropping and flagging overflow.
module fmrv32im_dbus_mailbox
  import fmrv32im_dbus_mailbox_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0800,
  parameter int          FIFO_DEPTH = 8,
  parameter int          FIFO_AW    = 3
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        D_MEM_ENA,
  input  logic [3:0]  D_MEM_WSTB,
  input  logic [31:0] D_MEM_ADDR,
  input  logic [31:0] D_MEM_WDATA,
  output logic [31:0] D_MEM_RDATA,
  output logic        D_MEM_WAIT,
  output logic        result_valid,
  output logic [31:0] result_data,
  input  logic        result_ready,
  output logic [3:0]  led
);

  dbus_dec_t      dec;
  logic [FIFO_AW:0] fifo_count;
  logic           fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [31:0]    fifo_head;
  logic           res_wr, push_blocked, ovf_set;
  logic [31:0]    read_mux;
  logic [31:0]    rdata_q, rdata_d;
  logic [31:0]    scratch_q, scratch_d;
  logic [31:0]    last_q, last_d;
  logic [3:0]     led_q, led_d;
  logic           ovf_q, ovf_d;
  logic           unused_addr_bits;

  assign unused_addr_bits = ^D_MEM_ADDR[1:0];

  always_comb begin
    dec.hit = D_MEM_ENA && (D_MEM_ADDR[31:4] == BASE_ADDR[31:4]);
    dec.rd  = dec.hit && (D_MEM_WSTB == 4'h0);
    dec.wr  = dec.hit && (D_MEM_WSTB != 4'h0);
    dec.ofs = D_MEM_ADDR[3:2];
  end

  assign fifo_pop     = result_valid && result_ready;
  assign res_wr       = dec.wr && (dec.ofs == OFS_RESULT) && (D_MEM_WSTB == 4'hF);
  assign push_blocked = res_wr && fifo_full && !fifo_pop;
  assign fifo_push    = res_wr && !push_blocked;

`ifdef MAILBOX_BACKPRESSURE_EN
  assign D_MEM_WAIT = push_blocked;
  assign ovf_set    = 1'b0;
`else
  assign D_MEM_WAIT = 1'b0;
  assign ovf_set    = push_blocked;
`endif

  fmrv32im_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (D_MEM_WDATA),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  always_comb begin
    case (dec.ofs)
      OFS_RESULT:  read_mux = last_q;
      OFS_STATUS:  read_mux = pack_status(ovf_q, fifo_full, fifo_empty, 5'(fifo_count));
      OFS_LED:     read_mux = {28'h0, led_q};
      default:     read_mux = scratch_q;
    endcase
  end

  always_comb begin
    led_d     = led_q;
    scratch_d = scratch_q;
    last_d    = last_q;
    ovf_d     = ovf_q | ovf_set;
    rdata_d   = rdata_q;
    if (fifo_push) last_d = D_MEM_WDATA;
    if (dec.wr) begin
      case (dec.ofs)
        OFS_STATUS:  if (D_MEM_WDATA[STAT_OVF_BIT]) ovf_d = 1'b0;
        OFS_LED:     if (D_MEM_WSTB[0]) led_d = D_MEM_WDATA[3:0];
        OFS_SCRATCH: scratch_d = apply_wstb(scratch_q, D_MEM_WDATA, D_MEM_WSTB);
        default:     ;
      endcase
    end
    // Read data holds between accesses; any non-read access (including misses) returns zero.
    if (D_MEM_ENA) rdata_d = dec.rd ? read_mux : 32'h0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdata_q   <= '0;
      scratch_q <= '0;
      last_q    <= '0;
      led_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      rdata_q   <= rdata_d;
      scratch_q <= scratch_d;
      last_q    <= last_d;
      led_q     <= led_d;
      ovf_q     <= ovf_d;
    end
  end

  assign D_MEM_RDATA  = rdata_q;
  assign result_valid = !fifo_empty;
  assign result_data  = fifo_head;
  assign led          = led_q;

endmodule

// File: tb/tb_fmrv32im_dbus_mailbox.sv
// Self-checking bench for fmrv32im_dbus_mailbox: directed scenarios then random bus traffic,
// all checked against a queue-based reference model of the mailbox.
module tb_fmrv32im_dbus_mailbox;

  localparam int DEPTH = 8;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [3:0]  wstb = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        rdy = 1'b0;
  logic [31:0] rdata;
  logic        wait_o;
  logic        res_valid;
  logic [31:0] res_data;
  logic [3:0]  led;

  always #5 clk_i = ~clk_i;

  fmrv32im_dbus_mailbox dut (
    .CLK          (clk_i),
    .RST_N        (rst_n),
    .D_MEM_ENA    (ena),
    .D_MEM_WSTB   (wstb),
    .D_MEM_ADDR   (addr),
    .D_MEM_WDATA  (wdata),
    .D_MEM_RDATA  (rdata),
    .D_MEM_WAIT   (wait_o),
    .result_valid (res_valid),
    .result_data  (res_data),
    .result_ready (rdy),
    .led          (led)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q[$];
  logic        m_ovf;
  logic [3:0]  m_led;
  logic [31:0] m_scratch, m_last, m_rdata;
  bit          m_rdata_known;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function logic [31:0] m_status();
    logic [31:0] s;
    s = 32'(q.size());
    if (m_ovf) s = s + 32'h8000;
    if (q.size() == DEPTH) s = s + 32'h80;
    if (q.size() == 0) s = s + 32'h40;
    return s;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_led = 4'h0;
    m_scratch = 32'h0;
    m_last = 32'h0;
    m_rdata = 32'h0;
    m_rdata_known = 1'b1;
  endtask

  // One bus cycle: drive, check WAIT mid-cycle, clock, update model, check registered outputs.
  task automatic cycle(input logic e, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, input logic r);
    logic       hit, pop, res_wr, wexp;
    logic [1:0] ofs;
    logic [31:0] rd_val;
    int         sz;
    ena = e; wstb = s; addr = a; wdata = d; rdy = r;
    hit    = e && (a[31:4] == 28'h000_0080);
    ofs    = a[3:2];
    sz     = q.size();
    pop    = r && (sz > 0);
    res_wr = hit && (ofs == 2'd0) && (s == 4'hF);
`ifdef MAILBOX_BACKPRESSURE_EN
    wexp = res_wr && (sz == DEPTH) && !pop;
`else
    wexp = 1'b0;
`endif
    case (ofs)
      2'd0:    rd_val = m_last;
      2'd1:    rd_val = m_status();
      2'd2:    rd_val = {28'h0, m_led};
      default: rd_val = m_scratch;
    endcase
    #2;
    check("wait", 32'(wait_o), 32'(wexp));
    @(posedge clk_i);
    if (e) begin
      m_rdata_known = (s == 4'h0) || !hit;
      m_rdata = (hit && s == 4'h0) ? rd_val : 32'h0;
    end
    if (pop) void'(q.pop_front());
    if (res_wr) begin
      if (sz < DEPTH || pop) begin
        q.push_back(d);
        m_last = d;
      end
`ifndef MAILBOX_BACKPRESSURE_EN
      else m_ovf = 1'b1;
`endif
    end
    if (hit && s != 4'h0) begin
      case (ofs)
        2'd1: if (d[15]) m_ovf = 1'b0;
        2'd2: if (s[0]) m_led = d[3:0];
        2'd3: for (int b = 0; b < 4; b++) if (s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
        default: ;
      endcase
    end
    #1;
    check("valid", 32'(res_valid), 32'(q.size() > 0));
    if (q.size() > 0) check("head", res_data, q[0]);
    check("led", 32'(led), 32'(m_led));
    if (m_rdata_known) check("rdata", rdata, m_rdata);
  endtask

  task automatic reset_mid(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_valid"}, 32'(res_valid), 32'h0);
    check({tag, "_data"}, res_data, 32'h0);
    check({tag, "_led"}, 32'(led), 32'h0);
    check({tag, "_wait"}, 32'(wait_o), 32'h0);
    ena = 1'b0; wstb = 4'h0; rdy = 1'b0;
    model_reset();
    @(negedge clk_i);
    rst_n = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_valid", 32'(res_valid), 32'h0);
    check("rst_data", res_data, 32'h0);
    check("rst_led", 32'(led), 32'h0);
    check("rst_wait", 32'(wait_o), 32'h0);
    @(negedge clk_i);
    rst_n = 1'b1;
    @(posedge clk_i);
    #1;

    // Single full-word push, then STATUS
    cycle(1, 4'hF, 32'h800, 32'h1234_5678, 0);
    check("t1_data", res_data, 32'h1234_5678);
    cycle(1, 4'h0, 32'h804, 32'h0, 0);
    check("t1_status", rdata, 32'h0000_0001);

    // LED byte write and a partial-strobe RESULT write
    cycle(1, 4'h1, 32'h808, 32'h0000_00A5, 0);
    check("t2_led", 32'(led), 32'h5);
    cycle(1, 4'h3, 32'h800, 32'h0000_FFFF, 0);
    cycle(1, 4'h0, 32'h806, 32'h0, 0);
    check("t2_status", rdata, 32'h0000_0001);

    // Fill to full, then one more
    for (int i = 0; i < 7; i++) cycle(1, 4'hF, 32'h800, 32'h100 + i, 0);
    cycle(1, 4'h0, 32'h804, 32'h0, 0);
    check("t3_full", rdata, 32'h0000_0088);
    cycle(1, 4'hF, 32'h800, 32'h999, 0);
`ifdef MAILBOX_BACKPRESSURE_EN
    cycle(1, 4'hF, 32'h800, 32'h999, 1);
    check("t3_tail", m_last, 32'h999);
`else
    cycle(1, 4'h0, 32'h804, 32'h0, 0);
    check("t3_ovf", rdata, 32'h0000_8088);
    cycle(1, 4'hF, 32'h804, 32'h0000_8000, 0);
    cycle(1, 4'h0, 32'h804, 32'h0, 0);
    check("t3_w1c", rdata, 32'h0000_0088);
`endif

    // Push and pop together while full, across pointer wrap
    for (int i = 0; i < 10; i++) cycle(1, 4'hF, 32'h800, 32'h4000 + i, 1);
    cycle(1, 4'h0, 32'h804, 32'h0, 0);
    check("t4_status", rdata, 32'h0000_0088);

    // SCRATCH readback and an out-of-window access
    cycle(1, 4'hF, 32'h80C, 32'hDEAD_BEEF, 0);
    cycle(1, 4'h0, 32'h80C, 32'h0, 0);
    check("t5_scratch", rdata, 32'hDEAD_BEEF);
    cycle(1, 4'hF, 32'h90C, 32'h1111_2222, 0);
    cycle(1, 4'h0, 32'h900, 32'h0, 0);
    check("t5_miss", rdata, 32'h0);
    cycle(1, 4'h0, 32'h80C, 32'h0, 0);
    check("t5_scratch2", rdata, 32'hDEAD_BEEF);
    cycle(1, 4'h0, 32'h800, 32'h0, 0);
    check("t5_result", rdata, 32'h4009);

    // Reset with words queued and a write in flight
    while (q.size() > 5) cycle(0, 4'h0, 32'h0, 32'h0, 1);
    ena = 1'b1; wstb = 4'hF; addr = 32'h800; wdata = 32'hCAFE_0001; rdy = 1'b0;
    #2;
    reset_mid("t6");
`ifdef MAILBOX_BACKPRESSURE_EN
    while (q.size() < DEPTH) cycle(1, 4'hF, 32'h800, $urandom, 0);
    ena = 1'b1; wstb = 4'hF; addr = 32'h800; wdata = 32'hCAFE_0002; rdy = 1'b0;
    #2;
    check("t6_wait_pre", 32'(wait_o), 32'h1);
    reset_mid("t6b");
`endif
    cycle(1, 4'h0, 32'h804, 32'h0, 0);
    check("t6_status", rdata, 32'h0000_0040);

    // Push+pop request on an empty FIFO
    cycle(1, 4'hF, 32'h800, 32'h5555_AAAA, 1);
    check("t7_valid", 32'(res_valid), 32'h1);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2, 3: a = 32'h800 + 32'(4 * $urandom_range(0, 3));
        4:          a = 32'h900;
        default:    a = $urandom;
      endcase
      a[1:0] = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       s = 4'h0;
        1:       s = 4'hF;
        default: s = 4'($urandom_range(1, 15));
      endcase
      d = $urandom;
      cycle($urandom_range(0, 3) != 0, s, a, d, $urandom_range(0, 2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
